adc_frame_align: RTL
====================

ADC_FRAME_ALIGN -- requirements
Module: adc_frame_align

Interface
REQ-001 Parameter FRAME_W, 8, width of the deserialized frame word.
REQ-002 Parameter TRAIN_PAT, 8'hF0, expected frame pattern when aligned.
REQ-003 Parameter SETTLE_CYC, 16, cycles waited after io reset release before checking.
REQ-004 Parameter SLIP_WAIT, 4, cycles waited after each bitslip pulse.
REQ-005 Parameter MATCH_N, 8, consecutive matching frames required to declare lock.
REQ-006 clk_adc  input  1  sole clock; all logic is on its rising edge.
REQ-007 rst_adc_n  input  1  reset, asynchronous assert, active-low.
REQ-008 sel_io_rst  input  1  SelectIO reset from the stream-domain reset block; asynchronous to clk_adc.
REQ-009 frame_data  input  FRAME_W  deserialized frame word, valid every cycle.
REQ-010 bitslip  output  1  single-cycle pulse to the ISERDES bitslip input.
REQ-011 aligned  output  1  high while in LOCKED.
REQ-012 align_err  output  1  high while in FAIL.
REQ-013 slip_cnt  output  4  bitslips issued since the last io reset, saturating at 15.

Function
REQ-014 sel_io_rst SHALL pass through a 2-flop synchronizer; io_rst_s denotes the synchronized level.
REQ-015 FSM states: IDLE, SETTLE, CHECK, SLIP, SLIP_WAIT, LOCKED, FAIL.
REQ-016 Any state: io_rst_s=1 -> IDLE next cycle; slip_cnt, counters cleared; takes priority over all other transitions.
REQ-017 IDLE: io_rst_s=0 -> SETTLE, settle counter loaded with SETTLE_CYC-1.
REQ-018 SETTLE: counter decrements each cycle; at 0 -> CHECK with match counter cleared.
REQ-019 CHECK: frame_data==TRAIN_PAT increments match counter; reaching MATCH_N -> LOCKED; a mismatch -> SLIP.
REQ-020 SLIP: bitslip=1 for exactly that cycle; slip_cnt increments (saturating); -> SLIP_WAIT loaded with SLIP_WAIT-1.
REQ-021 SLIP_WAIT: counter decrements; at 0 -> CHECK with match counter cleared.
REQ-022 When FRAME_W slips have been issued without lock, the next mismatch in CHECK SHALL go to FAIL instead of SLIP.
REQ-023 FAIL: align_err=1, no bitslip, held until io_rst_s=1 or reset.
REQ-024 LOCKED: aligned=1; frame_data is ignored unless ADC_FRAME_RELOCK_EN is defined.
REQ-025 Outputs SHALL be registered; aligned rises the cycle after the MATCH_N-th match is sampled.
REQ-026 bitslip SHALL never assert on two consecutive cycles.

Reset
REQ-027 rst_adc_n=0: state IDLE, bitslip=0, aligned=0, align_err=0, slip_cnt=0, synchronizer flops set to 1 (io reset treated as asserted).
REQ-028 After rst_adc_n release, the FSM leaves IDLE only after io_rst_s is sampled low.
REQ-029 Reset or io_rst_s mid-SLIP SHALL suppress any further bitslip pulse.

Configuration
REQ-030 Macro ADC_FRAME_RELOCK_EN defined: in LOCKED, 4 consecutive mismatching frames drop aligned and enter CHECK with slip_cnt cleared; any matching frame resets that mismatch count.
REQ-031 Macro ADC_FRAME_RELOCK_EN undefined: LOCKED is exited only by io_rst_s or rst_adc_n; mismatch logic absent.

Verification
REQ-032 frame_data=8'hF0 constant, sel_io_rst released -> aligned=1 at 2 (sync) + 1 + 16 + 8 + 1 cycles, slip_cnt=0, no bitslip.
REQ-033 Pattern rotated by 3 bits, each bitslip rotates it by 1 -> exactly 3 bitslip pulses at least 5 cycles apart, then aligned=1, slip_cnt=3.
REQ-034 frame_data=8'h00 constant -> 8 bitslip pulses, then align_err=1, aligned=0, slip_cnt=8.
REQ-035 sel_io_rst asserted during SLIP_WAIT -> no further bitslip, state IDLE within 3 cycles, slip_cnt=0.
REQ-036 With ADC_FRAME_RELOCK_EN: in LOCKED inject 3 bad frames -> aligned stays 1; inject 4 -> aligned=0, CHECK re-entered.
REQ-037 rst_adc_n pulsed low mid-CHECK -> all outputs 0 immediately (asynchronous), FSM restarts from IDLE.

Source files
------------

// File: rtl/adc_frame_align.sv
// adc_frame_align: trains an ISERDES frame word onto TRAIN_PAT by issuing bitslip pulses.
// Ports:
//   clk_adc    - sole clock, rising edge
//   rst_adc_n  - asynchronous active-low reset
//   sel_io_rst - SelectIO reset, asynchronous to clk_adc, resynchronized here
//   frame_data - deserialized frame word, valid every cycle
//   bitslip    - single-cycle pulse to the ISERDES bitslip input
//   aligned    - high while locked
//   align_err  - high once every bit position was tried without lock
//   slip_cnt   - bitslips issued since the last io reset, saturating at 15
// Optional feature: define ADC_FRAME_RELOCK_EN to let a locked link fall back to
// checking after 4 consecutive mismatching frames.
module adc_frame_align #(
  parameter int                 FRAME_W    = 8,
  parameter logic [FRAME_W-1:0] TRAIN_PAT  = 8'hF0,
  parameter int                 SETTLE_CYC = 16,
  parameter int                 SLIP_WAIT  = 4,
  parameter int                 MATCH_N    = 8
) (
  input  logic               clk_adc,
  input  logic               rst_adc_n,
  input  logic               sel_io_rst,
  input  logic [FRAME_W-1:0] frame_data,
  output logic               bitslip,
  output logic               aligned,
  output logic               align_err,
  output logic [3:0]         slip_cnt
);
  localparam int CMAX = (SETTLE_CYC > SLIP_WAIT) ? SETTLE_CYC : SLIP_WAIT;
  localparam int CW = $clog2(CMAX + 1);
  localparam int MW = $clog2(MATCH_N + 1);
  localparam logic [3:0] SLIP_MAX = 4'((FRAME_W > 15) ? 15 : FRAME_W);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_CHECK, S_SLIP, S_SLIP_W, S_LOCKED, S_FAIL
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      sync_q, sync_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [MW-1:0]   match_q, match_d;
  logic [3:0]      slip_cnt_q, slip_cnt_d;
  logic            bitslip_q, bitslip_d;
  logic            aligned_q, aligned_d;
  logic            align_err_q, align_err_d;
  logic            io_rst_s;
`ifdef ADC_FRAME_RELOCK_EN
  logic [1:0]      mis_q, mis_d;
`endif

  assign io_rst_s  = sync_q[1];
  assign sync_d    = {sync_q[0], sel_io_rst};
  assign bitslip   = bitslip_q;
  assign aligned   = aligned_q;
  assign align_err = align_err_q;
  assign slip_cnt  = slip_cnt_q;

  // Synchronizer resets to 1 so the io reset is treated as asserted until seen low.
  always_ff @(posedge clk_adc or negedge rst_adc_n) begin
    if (!rst_adc_n) begin
      sync_q      <= 2'b11;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      match_q     <= '0;
      slip_cnt_q  <= '0;
      bitslip_q   <= 1'b0;
      aligned_q   <= 1'b0;
      align_err_q <= 1'b0;
`ifdef ADC_FRAME_RELOCK_EN
      mis_q       <= '0;
`endif
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      match_q     <= match_d;
      slip_cnt_q  <= slip_cnt_d;
      bitslip_q   <= bitslip_d;
      aligned_q   <= aligned_d;
      align_err_q <= align_err_d;
`ifdef ADC_FRAME_RELOCK_EN
      mis_q       <= mis_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    match_d    = match_q;
    slip_cnt_d = slip_cnt_q;
`ifdef ADC_FRAME_RELOCK_EN
    mis_d      = mis_q;
`endif
    case (state_q)
      S_IDLE: begin
        state_d = S_SETTLE;
        cnt_d   = CW'(SETTLE_CYC - 1);
      end
      S_SETTLE, S_SLIP_W: begin
        if (cnt_q == '0) begin
          state_d = S_CHECK;
          match_d = '0;
        end else cnt_d = cnt_q - 1'b1;
      end
      S_CHECK: begin
        if (frame_data == TRAIN_PAT) begin
          match_d = match_q + 1'b1;
          if (match_q == MW'(MATCH_N - 1)) state_d = S_LOCKED;
`ifdef ADC_FRAME_RELOCK_EN
          mis_d = '0;
`endif
        end else state_d = (slip_cnt_q >= SLIP_MAX) ? S_FAIL : S_SLIP;
      end
      S_SLIP: begin
        state_d    = S_SLIP_W;
        cnt_d      = CW'(SLIP_WAIT - 1);
        slip_cnt_d = (slip_cnt_q == 4'hF) ? slip_cnt_q : slip_cnt_q + 1'b1;
      end
`ifdef ADC_FRAME_RELOCK_EN
      S_LOCKED: begin
        if (frame_data == TRAIN_PAT) mis_d = '0;
        else if (mis_q == 2'd3) begin
          state_d    = S_CHECK;
          match_d    = '0;
          slip_cnt_d = '0;
          mis_d      = '0;
        end else mis_d = mis_q + 1'b1;
      end
`endif
      default: ;
    endcase
    if (io_rst_s) begin
      state_d    = S_IDLE;
      cnt_d      = '0;
      match_d    = '0;
      slip_cnt_d = '0;
`ifdef ADC_FRAME_RELOCK_EN
      mis_d      = '0;
`endif
    end
  end

  // Gating with io_rst_s kills a pending bitslip when the io reset lands in SLIP.
  always_comb begin
    bitslip_d   = (state_q == S_SLIP) && !io_rst_s;
    aligned_d   = (state_q == S_LOCKED) && !io_rst_s;
    align_err_d = (state_q == S_FAIL) && !io_rst_s;
  end
endmodule
